// File: rtl/spu_fetch_pkg.sv
// Shared types and defaults for the fetch stage sequencing logic.
package spu_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int FLUSH_CNT_W      = 3;
  localparam int BITSIZE_DEF      = 11;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/fetch_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      count_q <= '0;
    else if (inc && (count_q != '1)) count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencing: PC enable/source, jump target and IF flush from
// redirect > halt > stall events, plus saturating performance counters.
module fetch_controller
  import spu_fetch_pkg::*;
#(
  parameter int bitsize      = BITSIZE_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_req,
  input  logic               redirect_valid,
  input  logic [bitsize-1:0] redirect_target,
  input  logic               halt_req,
  input  logic               resume,
  output logic               PC_enable,
  output logic               PC_source,
  output logic [bitsize-1:0] PC_jump,
  output logic               IF_flush,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count,
  output logic [CNT_W-1:0]   redirect_count
);

  localparam logic [FLUSH_CNT_W-1:0] RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  fetch_state_t           state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   en, src, flush, stall_inc;
  logic [bitsize-1:0]     jump;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    en        = 1'b0;
    src       = 1'b0;
    jump      = '0;
    flush     = 1'b1;
    stall_inc = 1'b0;
    if (redirect_valid) begin
      en      = 1'b1;
      src     = 1'b1;
      jump    = redirect_target;
      cnt_d   = RELOAD;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        HALT: if (resume) state_d = RUN;
        RUN, FLUSH: begin
          if (halt_req) begin
            state_d = HALT;
            cnt_d   = '0;
          end else begin
            en        = !stall_req;
            stall_inc = stall_req;
            flush     = (state_q == FLUSH);
            // FLUSH counts down even while stalled.
            if (state_q == FLUSH) begin
              cnt_d = cnt_q - 1'b1;
              if (cnt_q <= FLUSH_CNT_W'(1)) state_d = RUN;
            end
          end
        end
        default: state_d = BOOT;
      endcase
    end
    // Reset must win over a redirect that is present while reset is held.
    if (!reset) begin
      en        = 1'b0;
      src       = 1'b0;
      jump      = '0;
      flush     = 1'b1;
      stall_inc = 1'b0;
    end
  end

  assign PC_enable = en;
  assign PC_source = src;
  assign PC_jump   = jump;
  assign IF_flush  = flush;
  assign halted    = (state_q == HALT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_inc), .count(stall_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush && reset), .count(flush_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk(clk), .reset(reset), .inc(redirect_valid && reset), .count(redirect_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs from a
// rule-level model; a monitor pops and compares on the falling edge.
module tb_fetch_controller;

  localparam int BW   = 11;
  localparam int FC   = 3;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall_req = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [BW-1:0] redirect_target = '0;
  logic          PC_enable, PC_source, IF_flush, halted;
  logic [BW-1:0] PC_jump;
  logic [CW-1:0] stall_count, flush_count, redirect_count;

  fetch_controller #(.bitsize(BW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .resume(resume),
    .PC_enable(PC_enable), .PC_source(PC_source), .PC_jump(PC_jump),
    .IF_flush(IF_flush), .halted(halted), .stall_count(stall_count),
    .flush_count(flush_count), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit      en, src, flush, hlt;
    int      jump, sc, fc, rc;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;

  // Model: phase of the controller described by plain flags.
  bit m_boot = 1, m_halt = 0;
  int m_left = 0;
  int m_sc = 0, m_fc = 0, m_rc = 0;

  function automatic int sat_inc(int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic cyc(input bit rs, input bit r, input int t, input bit h,
                     input bit s, input bit res);
    exp_t e;
    @(posedge clk); #1;
    reset = rs; redirect_valid = r; redirect_target = BW'(t);
    halt_req = h; stall_req = s; resume = res;
    e = '{en:0, src:0, flush:1, hlt:0, jump:0, sc:0, fc:0, rc:0};
    if (!rs) begin
      m_boot = 1; m_halt = 0; m_left = 0; m_sc = 0; m_fc = 0; m_rc = 0;
    end else begin
      e.hlt = m_halt; e.sc = m_sc; e.fc = m_fc; e.rc = m_rc;
      if (r) begin
        e.en = 1; e.src = 1; e.jump = t & ((1 << BW) - 1);
        m_left = FC - 1; m_boot = 0; m_halt = 0; m_rc = sat_inc(m_rc);
      end else if (m_boot) begin
        m_boot = 0;
      end else if (m_halt) begin
        if (res) m_halt = 0;
      end else if (h) begin
        m_halt = 1; m_left = 0;
      end else begin
        e.flush = (m_left > 0);
        e.en = !s;
        if (s) m_sc = sat_inc(m_sc);
        if (m_left > 0) m_left--;
      end
      if (e.flush) m_fc = sat_inc(m_fc);
    end
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC_enable", PC_enable, e.en);
        chk("PC_source", PC_source, e.src);
        chk("PC_jump", PC_jump, e.jump);
        chk("IF_flush", IF_flush, e.flush);
        chk("halted", halted, e.hlt);
        chk("stall_count", stall_count, e.sc);
        chk("flush_count", flush_count, e.fc);
        chk("redirect_count", redirect_count, e.rc);
      end
    end
  end

  initial begin
    // reset, release into BOOT then RUN
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    // redirect in RUN, then flush tail
    cyc(1, 1, 'h2A0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    // 3-cycle stall, stray resume ignored
    repeat (3) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1);
    // all events at once: redirect wins
    cyc(1, 1, 'h155, 1, 1, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    // halt, stay halted ignoring stalls, resume
    cyc(1, 0, 0, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    // redirect from HALT, reload during FLUSH, stall in FLUSH
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 'h7FF, 0, 0, 0);
    cyc(1, 1, 'h011, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    // reset mid-FLUSH, asserted between clock edges
    cyc(1, 1, 'h3C3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 'h0AA, 0, 0, 0);   // redirect during BOOT
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    // random traffic; counters saturate at 6 bits
    for (int i = 0; i < 700; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2047)),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0));
    end
    // long stall stretch to drive stall_count into saturation
    repeat (MAXC + 4) cyc(1, 0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
